arith_req_sched: RTL
====================

Name: arith_req_sched

Overview:
Round-robin scheduler that shares one 2-stage arithmetic unit between NUM_REQ requesters. Each requester posts an operation (A, B, 2-bit function) with a valid/ready handshake. The block grants one request, drives the unit's enable and operands for exactly one cycle, captures result/flag/carry, and returns the result with a per-requester valid/ready handshake. It sits between the requester fabric and the arithmetic unit and owns all of the unit's inputs.

Parameters:
IN_DATA_WD, 16, operand width (signed)
OUT_WD, 2*IN_DATA_WD, result width (signed)
NUM_REQ, 4, number of requesters (2..8)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  async active-low reset
REQ_VALID  in  NUM_REQ  request pending, one bit per requester
REQ_READY  out  NUM_REQ  one-hot accept pulse
REQ_A  in  NUM_REQ*IN_DATA_WD  packed operand A; requester i in slice i
REQ_B  in  NUM_REQ*IN_DATA_WD  packed operand B
REQ_FUN  in  NUM_REQ*2  packed function: 00 add, 01 sub, 10 mul, 11 div
RSP_VALID  out  NUM_REQ  one-hot response valid
RSP_READY  in  NUM_REQ  response accept
RSP_DATA  out  OUT_WD  shared result bus
RSP_CARRY  out  1  captured carry
RSP_ERR  out  1  divide-by-zero or protocol error
ARITH_EN  out  1  unit enable, registered
ARITH_A, ARITH_B  out  IN_DATA_WD  unit operands, registered
ARITH_FUN  out  2  unit function, registered
ARITH_OUT  in  OUT_WD  unit result
ARITH_FLAG  in  1  unit result-valid flag
CARRY_OUT  in  1  unit carry

Behaviour:
- Reset (RST low, async): state IDLE; all outputs 0; RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- The unit registers its result one cycle after ARITH_EN is sampled high. Its result returns to 0 when enable is low.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQ_VALID is high, the rr_arbiter picks the first set bit searching from ptr+1 with wrap-around.
  - REQ_READY[g]=1 combinationally in that cycle only.
  - Latch operands, function and ID. Update ptr=g.
  - If FUN=11 and B==0: go to RESP with DATA=0, CARRY=0, ERR=1. The unit is never enabled.
  - Otherwise go to ISSUE.
- ISSUE: ARITH_EN=1 and ARITH_A/B/FUN=latched values for exactly this cycle, then go to WAIT.
- WAIT:
  - ARITH_EN=0. Capture ARITH_OUT and CARRY_OUT into the RSP registers.
  - ERR = ~ARITH_FLAG (the flag must be 1 here).
  - Go to RESP.
- RESP:
  - RSP_VALID[id]=1; DATA/CARRY/ERR are held stable.
  - On RSP_READY[id], go to IDLE next cycle.
  - RSP_READY on other bits is ignored.
  - No new request is accepted until the response completes: one operation in flight.
- Latency, accept to RSP_VALID: 3 cycles. Divide-by-zero: 1 cycle. Minimum period with ready held high: 4 cycles per op.
- ARITH_A/B/FUN hold their last value outside ISSUE; only ARITH_EN qualifies them.
- A requester dropping REQ_VALID before grant is allowed. Operands are sampled only at the grant cycle.
- Simultaneous requests: strict round-robin. No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: return to IDLE immediately, drop RSP_VALID and ARITH_EN, and lose the pending op. The unit's own reset clears its result.
- Arithmetic: the scheduler does no arithmetic except the B==0 compare. Results pass through unmodified (signed, OUT_WD).

Decomposition:
- Package arith_sched_pkg holds:
  - state encoding (2-bit enum IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - function codes FUN_ADD/SUB/MUL/DIV;
  - the NUM_REQ upper bound.
- One sub-module, rr_arbiter: combinational one-hot grant from the request vector and pointer, parameterised on NUM_REQ.

Test Plan:
- Req0 add A=5, B=-3 alone, RSP_READY high → REQ_READY[0] at T0, ARITH_EN only at T1, RSP_VALID[0] at T3 with DATA=2, ERR=0, back in IDLE at T4.
- Req2 mul A=-200, B=300 → DATA=-60000 (0xFFFF15A0), ERR=0; req2 div A=7, B=0 → RSP_VALID[2] at T1, DATA=0, ERR=1, ARITH_EN never asserted.
- REQ_VALID=1111 held continuously after reset, all ops add 1+1 → grant order 0,1,2,3,0 at 4-cycle spacing; each RSP_VALID carries the matching one-hot ID.
- RSP_READY[1] low for 10 cycles during req1 response → RSP_VALID/DATA stable, REQ_READY stays 0 despite other valid requests; accepted on the cycle ready rises.
- RST pulsed low during WAIT → all outputs 0 asynchronously; after release, the next request completes normally with requester 0 first in priority.
- ARITH_FLAG forced 0 in WAIT via model fault injection → RSP_ERR=1, DATA = the captured ARITH_OUT.

Source files
------------

// File: rtl/arith_sched_pkg.sv
// Shared types and constants for the round-robin arithmetic-unit scheduler.
package arith_sched_pkg;

    localparam int unsigned FUN_W       = 2;
    localparam int unsigned MAX_NUM_REQ = 8;

    localparam logic [FUN_W-1:0] FUN_ADD = 2'b00;
    localparam logic [FUN_W-1:0] FUN_SUB = 2'b01;
    localparam logic [FUN_W-1:0] FUN_MUL = 2'b10;
    localparam logic [FUN_W-1:0] FUN_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_div(input logic [FUN_W-1:0] fun);
        return fun == FUN_DIV;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk offsets 1..NUM_REQ so the last winner is considered last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/arith_req_sched.sv
// Shares one two-stage arithmetic unit between NUM_REQ requesters with
// round-robin grant and one operation in flight at a time.
module arith_req_sched
    import arith_sched_pkg::*;
#(
    parameter int unsigned IN_DATA_WD = 16,
    parameter int unsigned OUT_WD     = 2 * IN_DATA_WD,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ*IN_DATA_WD-1:0] REQ_A,
    input  logic [NUM_REQ*IN_DATA_WD-1:0] REQ_B,
    input  logic [NUM_REQ*FUN_W-1:0]      REQ_FUN,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    input  logic [NUM_REQ-1:0]            RSP_READY,
    output logic [OUT_WD-1:0]             RSP_DATA,
    output logic                          RSP_CARRY,
    output logic                          RSP_ERR,
    output logic                          ARITH_EN,
    output logic [IN_DATA_WD-1:0]         ARITH_A,
    output logic [IN_DATA_WD-1:0]         ARITH_B,
    output logic [FUN_W-1:0]              ARITH_FUN,
    input  logic [OUT_WD-1:0]             ARITH_OUT,
    input  logic                          ARITH_FLAG,
    input  logic                          CARRY_OUT
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_t                  state_q, state_nxt;
    logic [PTR_W-1:0]        ptr_q, ptr_nxt;
    logic [NUM_REQ-1:0]      id_q, id_nxt;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_nxt;
    logic [OUT_WD-1:0]       rsp_data_q, rsp_data_nxt;
    logic                    rsp_carry_q, rsp_carry_nxt;
    logic                    rsp_err_q, rsp_err_nxt;
    logic                    arith_en_q, arith_en_nxt;
    logic [IN_DATA_WD-1:0]   arith_a_q, arith_a_nxt;
    logic [IN_DATA_WD-1:0]   arith_b_q, arith_b_nxt;
    logic [FUN_W-1:0]        arith_fun_q, arith_fun_nxt;
    logic [NUM_REQ-1:0]      req_ready_c;

    logic [NUM_REQ-1:0]      grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    any_req;

    logic [IN_DATA_WD-1:0]   a_arr   [NUM_REQ];
    logic [IN_DATA_WD-1:0]   b_arr   [NUM_REQ];
    logic [FUN_W-1:0]        fun_arr [NUM_REQ];
    logic [IN_DATA_WD-1:0]   sel_a, sel_b;
    logic [FUN_W-1:0]        sel_fun;
    logic                    sel_div_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (REQ_VALID),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // Unpack the per-requester operand slices.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i]   = REQ_A[i*IN_DATA_WD +: IN_DATA_WD];
            b_arr[i]   = REQ_B[i*IN_DATA_WD +: IN_DATA_WD];
            fun_arr[i] = REQ_FUN[i*FUN_W +: FUN_W];
        end
    end

    assign sel_a        = a_arr[grant_idx];
    assign sel_b        = b_arr[grant_idx];
    assign sel_fun      = fun_arr[grant_idx];
    assign sel_div_zero = is_div(sel_fun) && (sel_b == '0);

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state_q;
        ptr_nxt       = ptr_q;
        id_nxt        = id_q;
        rsp_valid_nxt = rsp_valid_q;
        rsp_data_nxt  = rsp_data_q;
        rsp_carry_nxt = rsp_carry_q;
        rsp_err_nxt   = rsp_err_q;
        arith_en_nxt  = 1'b0;
        arith_a_nxt   = arith_a_q;
        arith_b_nxt   = arith_b_q;
        arith_fun_nxt = arith_fun_q;
        req_ready_c   = '0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready_c = grant;
                    id_nxt      = grant;
                    ptr_nxt     = grant_idx;
                    // Divide-by-zero is answered locally; the unit never sees it.
                    if (sel_div_zero) begin
                        rsp_data_nxt  = '0;
                        rsp_carry_nxt = 1'b0;
                        rsp_err_nxt   = 1'b1;
                        rsp_valid_nxt = grant;
                        state_nxt     = RESP;
                    end else begin
                        arith_a_nxt   = sel_a;
                        arith_b_nxt   = sel_b;
                        arith_fun_nxt = sel_fun;
                        arith_en_nxt  = 1'b1;
                        state_nxt     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                rsp_data_nxt  = ARITH_OUT;
                rsp_carry_nxt = CARRY_OUT;
                rsp_err_nxt   = ~ARITH_FLAG;
                rsp_valid_nxt = id_q;
                state_nxt     = RESP;
            end
            RESP: begin
                if (|(RSP_READY & id_q)) begin
                    rsp_valid_nxt = '0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            id_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            arith_en_q  <= 1'b0;
            arith_a_q   <= '0;
            arith_b_q   <= '0;
            arith_fun_q <= '0;
        end else begin
            state_q     <= state_nxt;
            ptr_q       <= ptr_nxt;
            id_q        <= id_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_data_q  <= rsp_data_nxt;
            rsp_carry_q <= rsp_carry_nxt;
            rsp_err_q   <= rsp_err_nxt;
            arith_en_q  <= arith_en_nxt;
            arith_a_q   <= arith_a_nxt;
            arith_b_q   <= arith_b_nxt;
            arith_fun_q <= arith_fun_nxt;
        end
    end

    // Accept pulse is combinational; masked so every output reads 0 in reset.
    assign REQ_READY = req_ready_c & {NUM_REQ{RST}};
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_CARRY = rsp_carry_q;
    assign RSP_ERR   = rsp_err_q;
    assign ARITH_EN  = arith_en_q;
    assign ARITH_A   = arith_a_q;
    assign ARITH_B   = arith_b_q;
    assign ARITH_FUN = arith_fun_q;

endmodule
